// File: rtl/idma_mc_ar_gen.sv
// idma_mc_ar_gen
// ---------------------------------------------------------------------------
// Multi-channel AXI read-address generator for the iDMA data path. Each of
// NUM_CH channels accepts one linear read command (start address + beat
// count), splits it into AXI INCR bursts of at most 2^AXI_LENW beats, and
// the channels share a single AR port through a round-robin arbiter.
// Optional features: a per-channel limit on outstanding bursts and
// splitting bursts at 4 KB boundaries. R beats are only observed, to retire
// outstanding bursts by ID.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  per-channel command handshake (ready = channel idle)
//   cmd_addr             packed per-channel start byte address
//   cmd_beats            packed per-channel total beat count
//   cfg_outstd           outstanding-burst limit per channel (0 means 16)
//   cfg_outstd_en        enable the outstanding limit
//   cfg_cross4k_en       1: bursts may cross 4 KB, 0: split at 4 KB
//   ar*                  AXI read-address channel (master side)
//   rvalid/rready/rlast  observed R handshake, rid identifies the channel
//   ch_done              one-cycle pulse when a channel's command completes
//   err_unexp_r          sticky: a burst retired with nothing outstanding,
//                        or with an ID outside the channel range
// ---------------------------------------------------------------------------
module idma_mc_ar_gen #(
    parameter int NUM_CH       = 4,
    parameter int AXI_DATA_WID = 256,
    parameter int AXI_ADDR_WID = 32,
    parameter int AXI_IDW      = 4,
    parameter int AXI_LENW     = 4,
    parameter int BEAT_WID     = 16
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [NUM_CH-1:0]              cmd_valid,
    output logic [NUM_CH-1:0]              cmd_ready,
    input  logic [NUM_CH*AXI_ADDR_WID-1:0] cmd_addr,
    input  logic [NUM_CH*BEAT_WID-1:0]     cmd_beats,
    input  logic [3:0]                     cfg_outstd,
    input  logic                           cfg_outstd_en,
    input  logic                           cfg_cross4k_en,
    output logic                           arvalid,
    output logic [AXI_IDW-1:0]             arid,
    output logic [AXI_ADDR_WID-1:0]        araddr,
    output logic [AXI_LENW-1:0]            arlen,
    output logic [2:0]                     arsize,
    output logic [1:0]                     arburst,
    output logic                           arlock,
    output logic [3:0]                     arcache,
    output logic [2:0]                     arprot,
    input  logic                           arready,
    input  logic                           rvalid,
    input  logic                           rready,
    input  logic                           rlast,
    input  logic [AXI_IDW-1:0]             rid,
    output logic [NUM_CH-1:0]              ch_done,
    output logic                           err_unexp_r
);

    localparam int BPB        = AXI_DATA_WID / 8;
    localparam int OFFW       = $clog2(BPB);
    localparam int MAXB       = 1 << AXI_LENW;
    localparam int PAGE_BEATS = 4096 / BPB;
    localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW         = 32;   // working width for burst-length math

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_ACTIVE,
        CH_DRAIN
    } ch_state_e;

    // Per-channel state
    ch_state_e               state_q [NUM_CH];
    ch_state_e               state_d [NUM_CH];
    logic [AXI_ADDR_WID-1:0] addr_q  [NUM_CH];
    logic [AXI_ADDR_WID-1:0] addr_d  [NUM_CH];
    logic [BEAT_WID-1:0]     rem_q   [NUM_CH];
    logic [BEAT_WID-1:0]     rem_d   [NUM_CH];
    logic [4:0]              ostd_q  [NUM_CH];
    logic [4:0]              ostd_d  [NUM_CH];

    // Burst sizing and arbitration
    logic [CW-1:0]           page_left [NUM_CH];
    logic [CW-1:0]           len       [NUM_CH];
    logic [NUM_CH-1:0]       elig;
    logic [4:0]              limit_eff;
    logic                    ar_free;
    logic                    cand_found;
    logic [CHW-1:0]          cand_idx;
    logic                    grant;
    logic [CHW-1:0]          rr_q, rr_d;

    // Retire path
    logic                    retire;
    logic                    rid_ok;
    logic                    err_d;

    assign arsize  = 3'(OFFW);
    assign arburst = 2'b01;
    assign arlock  = 1'b0;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign ar_free = !arvalid || arready;
    assign retire  = rvalid && rready && rlast;
    assign rid_ok  = 32'(rid) < 32'(NUM_CH);

    // A disabled limit still caps the 5-bit counter at 16.
    always_comb begin
        limit_eff = 5'd16;
        if (cfg_outstd_en && cfg_outstd != 4'd0) begin
            limit_eff = {1'b0, cfg_outstd};
        end
    end

    // Completion is visible as soon as a draining channel has nothing in
    // flight; the channel can take its next command in that same cycle.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_done[c]   = (state_q[c] == CH_DRAIN) && (ostd_q[c] == 5'd0);
            cmd_ready[c] = (state_q[c] == CH_IDLE) || ch_done[c];
        end
    end

    // Burst length per channel: min(rem, MAXB[, beats left in 4 KB page]).
    // Addresses are beat-aligned, so the page remainder is a whole count.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            page_left[c] = CW'(PAGE_BEATS) - CW'(addr_q[c][11:OFFW]);
            len[c]       = CW'(rem_q[c]);
            if (len[c] > CW'(MAXB)) begin
                len[c] = CW'(MAXB);
            end
            if (!cfg_cross4k_en && len[c] > page_left[c]) begin
                len[c] = page_left[c];
            end
            elig[c] = (state_q[c] == CH_ACTIVE) && (rem_q[c] != '0) &&
                      (ostd_q[c] < limit_eff);
        end
    end

    // Round-robin: scan from rr_q (the channel after the last grant).
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            int idx;
            idx = int'(rr_q) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!cand_found && elig[idx]) begin
                cand_found = 1'b1;
                cand_idx   = CHW'(idx);
            end
        end
    end

    assign grant = cand_found && ar_free;

    always_comb begin
        rr_d = rr_q;
        if (grant) begin
            rr_d = (int'(cand_idx) == NUM_CH - 1) ? '0 : cand_idx + CHW'(1);
        end
    end

    // Per-channel next state.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so a path that
        // does not assign it keeps the registered value instead of a latch.
        err_d = err_unexp_r;
        if (retire && !rid_ok) begin
            err_d = 1'b1;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            logic granted;
            logic retired;
            logic load;
            state_d[c] = state_q[c];
            addr_d[c]  = addr_q[c];
            rem_d[c]   = rem_q[c];
            ostd_d[c]  = ostd_q[c];

            granted = grant && (cand_idx == CHW'(c));
            retired = retire && (32'(rid) == 32'(c));
            load    = cmd_valid[c] && cmd_ready[c];

            // A retire against an empty counter is an error and is dropped.
            if (retired && ostd_q[c] == 5'd0) begin
                err_d = 1'b1;
            end
            if (granted && !(retired && ostd_q[c] != 5'd0)) begin
                ostd_d[c] = ostd_q[c] + 5'd1;
            end else if (!granted && retired && ostd_q[c] != 5'd0) begin
                ostd_d[c] = ostd_q[c] - 5'd1;
            end

            if (load) begin
                addr_d[c]  = cmd_addr[c*AXI_ADDR_WID +: AXI_ADDR_WID] &
                             ~AXI_ADDR_WID'(BPB - 1);
                rem_d[c]   = cmd_beats[c*BEAT_WID +: BEAT_WID];
                state_d[c] = (cmd_beats[c*BEAT_WID +: BEAT_WID] == '0) ?
                             CH_DRAIN : CH_ACTIVE;
            end else begin
                unique case (state_q[c])
                    CH_IDLE: ;
                    CH_ACTIVE: begin
                        if (granted) begin
                            addr_d[c] = addr_q[c] + (AXI_ADDR_WID'(len[c]) << OFFW);
                            rem_d[c]  = rem_q[c] - BEAT_WID'(len[c]);
                            if (CW'(rem_q[c]) == len[c]) begin
                                state_d[c] = CH_DRAIN;
                            end
                        end else if (rem_q[c] == '0) begin
                            state_d[c] = CH_DRAIN;
                        end
                    end
                    CH_DRAIN: begin
                        if (ostd_q[c] == 5'd0) begin
                            state_d[c] = CH_IDLE;
                        end
                    end
                    default: state_d[c] = CH_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // NOTE: the per-channel arrays are small flop banks, not RAM, so
            // they are reset like any other control register.
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= CH_IDLE;
                addr_q[c]  <= '0;
                rem_q[c]   <= '0;
                ostd_q[c]  <= '0;
            end
            rr_q        <= '0;
            err_unexp_r <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed by the combinational blocks.
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                addr_q[c]  <= addr_d[c];
                rem_q[c]   <= rem_d[c];
                ostd_q[c]  <= ostd_d[c];
            end
            rr_q        <= rr_d;
            err_unexp_r <= err_d;
        end
    end

    // AR output register: loads only when free, so a stalled request keeps
    // address, length and ID stable until it is accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arvalid <= 1'b0;
            araddr  <= '0;
            arlen   <= '0;
            arid    <= '0;
        end else if (grant) begin
            arvalid <= 1'b1;
            araddr  <= addr_q[cand_idx];
            arlen   <= AXI_LENW'(len[cand_idx] - CW'(1));
            arid    <= AXI_IDW'(cand_idx);
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_idma_mc_ar_gen.sv
module tb_idma_mc_ar_gen;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [3:0]   cmd_valid;
    logic [3:0]   cmd_ready;
    logic [127:0] cmd_addr;
    logic [63:0]  cmd_beats;
    logic [3:0]   cfg_outstd;
    logic         cfg_outstd_en;
    logic         cfg_cross4k_en;
    logic         arvalid;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [3:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arlock;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic         arready;
    logic         rvalid, rready, rlast;
    logic [3:0]   rid;
    logic [3:0]   ch_done;
    logic         err_unexp_r;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] q_addr[$];
    logic [3:0]  q_len[$];
    logic [3:0]  q_id[$];
    int          q_cyc[$];

    idma_mc_ar_gen dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .cfg_outstd(cfg_outstd), .cfg_outstd_en(cfg_outstd_en),
        .cfg_cross4k_en(cfg_cross4k_en),
        .arvalid(arvalid), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rid(rid),
        .ch_done(ch_done), .err_unexp_r(err_unexp_r)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        aresetn        = 1'b0;
        cmd_valid      = '0;
        cmd_addr       = '0;
        cmd_beats      = '0;
        cfg_outstd     = 4'd0;
        cfg_outstd_en  = 1'b0;
        cfg_cross4k_en = 1'b1;
        arready        = 1'b1;
        rvalid         = 1'b0;
        rready         = 1'b1;
        rlast          = 1'b0;
        rid            = '0;
        q_addr.delete(); q_len.delete(); q_id.delete(); q_cyc.delete();
        tick();
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic issue(input int ch, input logic [31:0] addr, input logic [15:0] beats);
        cmd_valid[ch]         = 1'b1;
        cmd_addr[ch*32 +: 32] = addr;
        cmd_beats[ch*16 +: 16] = beats;
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            if (arvalid && arready) begin
                q_addr.push_back(araddr);
                q_len.push_back(arlen);
                q_id.push_back(arid);
                q_cyc.push_back(cyc);
            end
            tick();
        end
    endtask

    task automatic send_rlast(input logic [3:0] id);
        rvalid = 1'b1;
        rlast  = 1'b1;
        rid    = id;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #2;
        checks++; if (arvalid !== 1'b0 || araddr !== 32'h0 || arlen !== 4'h0 || arid !== 4'h0) begin
            errors++; $display("FAIL reset_ar: got v=%b a=%h l=%h id=%h, want 0/0/0/0", arvalid, araddr, arlen, arid);
        end
        checks++; if (cmd_ready !== 4'b1111 || ch_done !== 4'b0000 || err_unexp_r !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: got rdy=%b done=%b err=%b, want 1111/0000/0", cmd_ready, ch_done, err_unexp_r);
        end
        checks++; if (arsize !== 3'd5 || arburst !== 2'b01 || arlock !== 1'b0 || arcache !== 4'h0 || arprot !== 3'h0) begin
            errors++; $display("FAIL const_ar: got size=%0d burst=%b lock=%b cache=%h prot=%h, want 5/01/0/0/0",
                               arsize, arburst, arlock, arcache, arprot);
        end
    endtask

    task automatic test_cross4k();
        int c0;
        do_reset();
        cfg_cross4k_en = 1'b1;
        issue(0, 32'h1000, 16'd40);
        c0 = cyc;
        tick();
        cmd_valid = '0;
        collect(8);
        checks++; if (q_addr.size() != 3) begin
            errors++; $display("FAIL cross4k_count: got %0d ARs, want 3", q_addr.size());
        end else begin
            checks++; if (q_cyc[0] != c0 + 2) begin
                errors++; $display("FAIL cross4k_latency: first AR at +%0d, want +2", q_cyc[0] - c0);
            end
            checks++; if (q_addr[0] !== 32'h1000 || q_len[0] !== 4'd15 ||
                          q_addr[1] !== 32'h1200 || q_len[1] !== 4'd15 ||
                          q_addr[2] !== 32'h1400 || q_len[2] !== 4'd7) begin
                errors++; $display("FAIL cross4k_bursts: got %h/%0d %h/%0d %h/%0d, want 1000/15 1200/15 1400/7",
                                   q_addr[0], q_len[0], q_addr[1], q_len[1], q_addr[2], q_len[2]);
            end
            checks++; if (q_id[0] !== 4'd0 || q_id[1] !== 4'd0 || q_id[2] !== 4'd0 || arvalid !== 1'b0) begin
                errors++; $display("FAIL cross4k_ids: got %0d %0d %0d arvalid=%b, want 0 0 0 arvalid=0",
                                   q_id[0], q_id[1], q_id[2], arvalid);
            end
        end
        send_rlast(4'd0);
        send_rlast(4'd0);
        checks++; if (ch_done !== 4'b0000) begin
            errors++; $display("FAIL cross4k_early_done: got %b, want 0000", ch_done);
        end
        send_rlast(4'd0);
        checks++; if (ch_done !== 4'b0001 || cmd_ready[0] !== 1'b1) begin
            errors++; $display("FAIL cross4k_done: got done=%b rdy0=%b, want 0001/1", ch_done, cmd_ready[0]);
        end
        tick();
        checks++; if (ch_done !== 4'b0000) begin
            errors++; $display("FAIL cross4k_done_pulse: got %b, want 0000", ch_done);
        end
    endtask

    task automatic test_split4k();
        do_reset();
        cfg_cross4k_en = 1'b0;
        issue(0, 32'h0FC0, 16'd4);
        tick();
        cmd_valid = '0;
        collect(6);
        checks++; if (q_addr.size() != 2) begin
            errors++; $display("FAIL split4k_count: got %0d ARs, want 2", q_addr.size());
        end else begin
            checks++; if (q_addr[0] !== 32'h0FC0 || q_len[0] !== 4'd1 || q_addr[1] !== 32'h1000 || q_len[1] !== 4'd1) begin
                errors++; $display("FAIL split4k_bursts: got %h/%0d %h/%0d, want 0fc0/1 1000/1",
                                   q_addr[0], q_len[0], q_addr[1], q_len[1]);
            end
        end
        send_rlast(4'd0);
        send_rlast(4'd0);
        tick();
        q_addr.delete(); q_len.delete(); q_id.delete(); q_cyc.delete();
        cfg_cross4k_en = 1'b1;
        issue(0, 32'h0FC0, 16'd4);
        tick();
        cmd_valid = '0;
        collect(6);
        checks++; if (q_addr.size() != 1) begin
            errors++; $display("FAIL nosplit_count: got %0d ARs, want 1", q_addr.size());
        end else begin
            checks++; if (q_addr[0] !== 32'h0FC0 || q_len[0] !== 4'd3) begin
                errors++; $display("FAIL nosplit_burst: got %h/%0d, want 0fc0/3", q_addr[0], q_len[0]);
            end
        end
        send_rlast(4'd0);
    endtask

    task automatic test_outstanding();
        do_reset();
        cfg_outstd_en = 1'b1;
        cfg_outstd    = 4'd2;
        issue(0, 32'h0, 16'd64);
        tick();
        cmd_valid = '0;
        collect(10);
        checks++; if (q_addr.size() != 2 || arvalid !== 1'b0) begin
            errors++; $display("FAIL ostd_limit: got %0d ARs arvalid=%b, want 2/0", q_addr.size(), arvalid);
        end
        send_rlast(4'd0);
        collect(6);
        checks++; if (q_addr.size() != 3) begin
            errors++; $display("FAIL ostd_third: got %0d ARs, want 3", q_addr.size());
        end else begin
            checks++; if (q_addr[2] !== 32'h400 || q_len[2] !== 4'd15) begin
                errors++; $display("FAIL ostd_third_addr: got %h/%0d, want 400/15", q_addr[2], q_len[2]);
            end
        end
        send_rlast(4'd0);
        collect(6);
        checks++; if (q_addr.size() != 4 || arvalid !== 1'b0) begin
            errors++; $display("FAIL ostd_total: got %0d ARs arvalid=%b, want 4/0", q_addr.size(), arvalid);
        end
        send_rlast(4'd0);
        send_rlast(4'd0);
        checks++; if (ch_done !== 4'b0001 || err_unexp_r !== 1'b0) begin
            errors++; $display("FAIL ostd_done: got done=%b err=%b, want 0001/0", ch_done, err_unexp_r);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        cfg_cross4k_en = 1'b0;
        for (int c = 0; c < 4; c++) issue(c, 32'h2000 + 32'(c) * 32'h1000, 16'd16);
        tick();
        cmd_valid = '0;
        collect(8);
        checks++; if (q_addr.size() != 4) begin
            errors++; $display("FAIL rr_count: got %0d ARs, want 4", q_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (q_id[i] !== 4'(i) || q_addr[i] !== 32'h2000 + 32'(i) * 32'h1000 ||
                              q_len[i] !== 4'd15 || q_cyc[i] != q_cyc[0] + i) begin
                    errors++; $display("FAIL rr_slot%0d: got id=%0d a=%h l=%0d dcyc=%0d, want id=%0d l=15 dcyc=%0d",
                                       i, q_id[i], q_addr[i], q_len[i], q_cyc[i] - q_cyc[0], i, i);
                end
            end
        end
        for (int c = 0; c < 4; c++) send_rlast(4'(c));
        checks++; if (ch_done !== 4'b1000 || err_unexp_r !== 1'b0) begin
            errors++; $display("FAIL rr_done: got done=%b err=%b, want 1000/0", ch_done, err_unexp_r);
        end
    endtask

    task automatic test_backpressure();
        logic stable_ok;
        do_reset();
        arready = 1'b0;
        issue(0, 32'h0, 16'd32);
        tick();
        cmd_valid = '0;
        tick();
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (arvalid !== 1'b1 || araddr !== 32'h0 || arlen !== 4'd15 || arid !== 4'd0) stable_ok = 1'b0;
            tick();
        end
        checks++; if (stable_ok !== 1'b1) begin
            errors++; $display("FAIL bp_stable: got stable=%b, want 1", stable_ok);
        end
        arready = 1'b1;
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h0) begin
            errors++; $display("FAIL bp_hold: got v=%b a=%h, want 1/0", arvalid, araddr);
        end
        tick();
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h200 || arlen !== 4'd15) begin
            errors++; $display("FAIL bp_next: got v=%b a=%h l=%0d, want 1/200/15", arvalid, araddr, arlen);
        end
        tick();
        checks++; if (arvalid !== 1'b0) begin
            errors++; $display("FAIL bp_idle: got v=%b, want 0", arvalid);
        end
    endtask

    task automatic test_zero_beats();
        do_reset();
        issue(2, 32'h3000, 16'd0);
        tick();
        cmd_valid = '0;
        checks++; if (ch_done !== 4'b0100 || cmd_ready[2] !== 1'b1 || arvalid !== 1'b0) begin
            errors++; $display("FAIL zero_done: got done=%b rdy2=%b v=%b, want 0100/1/0", ch_done, cmd_ready[2], arvalid);
        end
        tick();
        checks++; if (ch_done !== 4'b0000 || arvalid !== 1'b0) begin
            errors++; $display("FAIL zero_after: got done=%b v=%b, want 0000/0", ch_done, arvalid);
        end
    endtask

    task automatic test_unexpected_r();
        do_reset();
        checks++; if (err_unexp_r !== 1'b0) begin
            errors++; $display("FAIL unexp_clear: got %b, want 0", err_unexp_r);
        end
        send_rlast(4'd1);
        checks++; if (err_unexp_r !== 1'b1) begin
            errors++; $display("FAIL unexp_set: got %b, want 1", err_unexp_r);
        end
        tick();
        checks++; if (err_unexp_r !== 1'b1) begin
            errors++; $display("FAIL unexp_sticky: got %b, want 1", err_unexp_r);
        end
        do_reset();
        send_rlast(4'd5);
        checks++; if (err_unexp_r !== 1'b1) begin
            errors++; $display("FAIL unexp_badid: got %b, want 1", err_unexp_r);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        arready = 1'b0;
        issue(0, 32'h0, 16'd32);
        tick();
        cmd_valid = '0;
        tick();
        checks++; if (arvalid !== 1'b1 || cmd_ready !== 4'b1110) begin
            errors++; $display("FAIL mid_pre: got v=%b rdy=%b, want 1/1110", arvalid, cmd_ready);
        end
        #2;
        aresetn = 1'b0;
        #1;
        checks++; if (arvalid !== 1'b0 || cmd_ready !== 4'b1111) begin
            errors++; $display("FAIL mid_async: got v=%b rdy=%b, want 0/1111", arvalid, cmd_ready);
        end
        tick();
        aresetn = 1'b1;
        arready = 1'b1;
        tick();
        tick();
        checks++; if (arvalid !== 1'b0 || cmd_ready !== 4'b1111 || ch_done !== 4'b0000) begin
            errors++; $display("FAIL mid_release: got v=%b rdy=%b done=%b, want 0/1111/0000", arvalid, cmd_ready, ch_done);
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_cross4k();
        test_split4k();
        test_outstanding();
        test_round_robin();
        test_backpressure();
        test_zero_beats();
        test_unexpected_r();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
